m_memarb: RTL and testbench

Single-port memory arbiter for the pipelined processor. It shares one `m_memory` instance (4K x 32, synchronous read, 1-cycle read latency) between three requesters:
- the MEM-stage data access;
- the IF-stage instruction fetch;
- an optional bulk loader.

Arbitration uses fixed priority with a fetch anti-starvation counter, plus a loader-ownership state machine. Read data returns through a shared bus tagged by per-requester valid strobes.

---
 rtl/m_memarb.sv | 122 ++++++++++++
 tb/tb_m_memarb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_memarb.sv
// m_memarb: single-port memory arbiter for data, fetch and bulk loader.
// Loader port and LOAD state exist only with `define MEMARB_LOADER_EN.
module m_memarb #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  input  logic          w_dreq,
  input  logic          w_dwe,
  input  logic [AW-1:0] w_daddr,
  input  logic [DW-1:0] w_ddin,
  output logic          w_dgnt,
  output logic          r_dvalid,
  input  logic          w_ireq,
  input  logic [AW-1:0] w_iaddr,
  output logic          w_ignt,
  output logic          r_ivalid,
  input  logic          w_lreq,
  input  logic          w_lwe,
  input  logic [AW-1:0] w_laddr,
  input  logic [DW-1:0] w_ldin,
  output logic          w_lgnt,
  output logic          r_lvalid,
  output logic [AW-1:0] w_maddr,
  output logic          w_mwe,
  output logic [DW-1:0] w_mdin,
  input  logic [DW-1:0] w_mdout,
  output logic [DW-1:0] w_rdata,
  output logic [3:0]    r_fcnt
);

  typedef enum logic {RUN, LOAD} state_t;

  localparam logic [3:0] FMAX = 4'(STARVE_MAX);

  state_t state, state_nx;
  logic   starved;

  assign starved = w_ireq && (r_fcnt == FMAX);
  assign w_rdata = w_mdout;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) state <= RUN;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
`ifdef MEMARB_LOADER_EN
    unique case (state)
      RUN:  if (w_lreq && !w_dgnt && !w_ignt)
              state_nx = LOAD;
      LOAD: if (!w_lreq)
              state_nx = RUN;
      default: state_nx = RUN;
    endcase
`else
    state_nx = RUN;
`endif
  end

  always_comb begin
    w_dgnt  = 1'b0;
    w_ignt  = 1'b0;
    w_lgnt  = 1'b0;
    if (state == RUN) begin
      w_ignt = w_ireq && (starved || !w_dreq);
      w_dgnt = w_dreq && !starved;
    end else begin
`ifdef MEMARB_LOADER_EN
      w_lgnt = w_lreq;
`endif
    end
  end

  always_comb begin
    w_maddr = '0;
    w_mwe   = 1'b0;
    w_mdin  = '0;
    unique case (1'b1)
      w_dgnt: begin
        w_maddr = w_daddr;
        w_mwe   = w_dwe;
        w_mdin  = w_ddin;
      end
      w_ignt: w_maddr = w_iaddr;
      w_lgnt: begin
        w_maddr = w_laddr;
        w_mwe   = w_lwe;
        w_mdin  = w_ldin;
      end
      default: ;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dvalid <= 1'b0;
      r_ivalid <= 1'b0;
      r_lvalid <= 1'b0;
    end else begin
      r_dvalid <= w_dgnt && !w_dwe;
      r_ivalid <= w_ignt;
      r_lvalid <= w_lgnt && !w_lwe;
    end
  end

  // Counter is frozen while the loader owns the port.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_fcnt <= 4'd0;
    end else if (state == RUN) begin
      if (w_ireq && !w_ignt)
        r_fcnt <= (r_fcnt == FMAX) ? FMAX : r_fcnt + 4'd1;
      else
        r_fcnt <= 4'd0;
    end
  end

endmodule

// File: tb/tb_m_memarb.sv
// tb_m_memarb: directed bench for m_memarb with a behavioral 4K x 32 memory.
// Loader checks follow `define MEMARB_LOADER_EN.
module tb_m_memarb;

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic        w_dreq, w_dwe;
  logic [11:0] w_daddr;
  logic [31:0] w_ddin;
  logic        w_dgnt, r_dvalid;
  logic        w_ireq;
  logic [11:0] w_iaddr;
  logic        w_ignt, r_ivalid;
  logic        w_lreq, w_lwe;
  logic [11:0] w_laddr;
  logic [31:0] w_ldin;
  logic        w_lgnt, r_lvalid;
  logic [11:0] w_maddr;
  logic        w_mwe;
  logic [31:0] w_mdin, w_mdout, w_rdata;
  logic [3:0]  r_fcnt;

  int n_cmp = 0;
  int n_bad = 0;

  m_memarb #(.AW(12), .DW(32), .STARVE_MAX(4)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n),
    .w_dreq(w_dreq), .w_dwe(w_dwe),
    .w_daddr(w_daddr), .w_ddin(w_ddin),
    .w_dgnt(w_dgnt), .r_dvalid(r_dvalid),
    .w_ireq(w_ireq), .w_iaddr(w_iaddr),
    .w_ignt(w_ignt), .r_ivalid(r_ivalid),
    .w_lreq(w_lreq), .w_lwe(w_lwe),
    .w_laddr(w_laddr), .w_ldin(w_ldin),
    .w_lgnt(w_lgnt), .r_lvalid(r_lvalid),
    .w_maddr(w_maddr), .w_mwe(w_mwe),
    .w_mdin(w_mdin), .w_mdout(w_mdout),
    .w_rdata(w_rdata), .r_fcnt(r_fcnt)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [31:0] init_val(input int a);
    return 32'h5A00_0000 + 32'(a) * 32'd3;
  endfunction

  logic [31:0] mem [4096];
  bit          mem_ok = 1'b0;

  always @(posedge w_clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
      mem_ok = 1'b1;
    end
    w_mdout <= mem[w_maddr];
    if (w_mwe) mem[w_maddr] = w_mdin;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic idle();
    w_dreq = 0; w_dwe = 0; w_daddr = '0; w_ddin = '0;
    w_ireq = 0; w_iaddr = '0;
    w_lreq = 0; w_lwe = 0; w_laddr = '0; w_ldin = '0;
  endtask

  initial begin
    logic exp_i;
    idle();
    w_rst_n = 0;
    #12;
    chk("rst_dvalid", 32'(r_dvalid), 0);
    chk("rst_ivalid", 32'(r_ivalid), 0);
    chk("rst_lvalid", 32'(r_lvalid), 0);
    chk("rst_fcnt", 32'(r_fcnt), 0);
    chk("rst_mwe", 32'(w_mwe), 0);
    @(posedge w_clk); #1;
    w_rst_n = 1;

    // Pending read plus starving fetch, then reset mid-flight.
    w_dreq = 1; w_daddr = 12'd3; w_ireq = 1; w_iaddr = 12'd4;
    tick();
    tick();
    chk("pre_fcnt", 32'(r_fcnt), 2);
    chk("pre_dvalid", 32'(r_dvalid), 1);
    w_rst_n = 0;
    #1;
    chk("midrst_dvalid", 32'(r_dvalid), 0);
    chk("midrst_fcnt", 32'(r_fcnt), 0);
    idle();
    #1;
    w_rst_n = 1;
    tick();

    // Lone fetch of address 5.
    w_ireq = 1; w_iaddr = 12'd5;
    #1;
    chk("f5_ignt", 32'(w_ignt), 1);
    chk("f5_dgnt", 32'(w_dgnt), 0);
    chk("f5_maddr", 32'(w_maddr), 5);
    tick();
    chk("f5_ivalid", 32'(r_ivalid), 1);
    chk("f5_rdata", w_rdata, init_val(5));
    idle();

    // Data vs fetch contention: 4 data grants then one forced fetch.
    w_dreq = 1; w_daddr = 12'd7; w_ireq = 1; w_iaddr = 12'd9;
    for (int c = 0; c < 10; c++) begin
      exp_i = (c % 5 == 4);
      #1;
      chk($sformatf("pri%0d_dgnt", c), 32'(w_dgnt), 32'(!exp_i));
      chk($sformatf("pri%0d_ignt", c), 32'(w_ignt), 32'(exp_i));
      chk($sformatf("pri%0d_fcnt", c), 32'(r_fcnt), c % 5);
      tick();
      chk($sformatf("pri%0d_dv", c), 32'(r_dvalid), 32'(!exp_i));
      chk($sformatf("pri%0d_iv", c), 32'(r_ivalid), 32'(exp_i));
      chk($sformatf("pri%0d_rd", c), w_rdata,
          exp_i ? init_val(9) : init_val(7));
    end
    idle();

    // Write then fetch-read of the same address.
    w_dreq = 1; w_dwe = 1; w_daddr = 12'h010; w_ddin = 32'hDEADBEEF;
    #1;
    chk("wr_mwe", 32'(w_mwe), 1);
    chk("wr_mdin", w_mdin, 32'hDEADBEEF);
    tick();
    chk("wr_novalid", 32'(r_dvalid), 0);
    idle();
    w_ireq = 1; w_iaddr = 12'h010;
    tick();
    chk("raw_ivalid", 32'(r_ivalid), 1);
    chk("raw_rdata", w_rdata, 32'hDEADBEEF);
    idle();
    #1;
    chk("idle_maddr", 32'(w_maddr), 0);
    chk("idle_mwe", 32'(w_mwe), 0);
    chk("idle_mdin", w_mdin, 0);
    tick();

`ifdef MEMARB_LOADER_EN
    // Loader waits behind a busy data port.
    w_dreq = 1; w_daddr = 12'd1; w_lreq = 1; w_lwe = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("lw%0d_lgnt", c), 32'(w_lgnt), 0);
      chk($sformatf("lw%0d_dgnt", c), 32'(w_dgnt), 1);
      tick();
    end
    w_dreq = 0;
    #1;
    chk("lx_lgnt", 32'(w_lgnt), 0);
    tick();
    w_ireq = 1; w_iaddr = 12'd3;
    for (int c = 0; c < 8; c++) begin
      w_laddr = 12'(c); w_ldin = 32'hA000_0000 + 32'(c);
      #1;
      chk($sformatf("ld%0d_lgnt", c), 32'(w_lgnt), 1);
      chk($sformatf("ld%0d_ignt", c), 32'(w_ignt), 0);
      chk($sformatf("ld%0d_maddr", c), 32'(w_maddr), c);
      chk($sformatf("ld%0d_mwe", c), 32'(w_mwe), 1);
      tick();
    end
    chk("ld_fcnt_hold", 32'(r_fcnt), 0);
    w_lwe = 0; w_laddr = 12'd6;
    #1;
    chk("lrd_lgnt", 32'(w_lgnt), 1);
    tick();
    w_lreq = 0;
    chk("lrd_lvalid", 32'(r_lvalid), 1);
    chk("lrd_rdata", w_rdata, 32'hA000_0006);
    tick();
    #1;
    chk("resume_ignt", 32'(w_ignt), 1);
    tick();
    chk("resume_ivalid", 32'(r_ivalid), 1);
    chk("resume_rdata", w_rdata, 32'hA000_0003);
    idle();

    // Reset while in LOAD.
    w_lreq = 1;
    tick();
    w_ireq = 1; w_iaddr = 12'd2;
    #1;
    chk("rl_ignt_load", 32'(w_ignt), 0);
    w_rst_n = 0;
    #1;
    w_rst_n = 1;
    #1;
    chk("rl_ignt_run", 32'(w_ignt), 1);
    chk("rl_lgnt_run", 32'(w_lgnt), 0);
    idle();
    tick();
`else
    // Loader inputs have no effect without the LOAD state.
    w_lreq = 1; w_laddr = 12'd4;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("nl%0d_lgnt", c), 32'(w_lgnt), 0);
      tick();
      chk($sformatf("nl%0d_lvalid", c), 32'(r_lvalid), 0);
    end
    w_dreq = 1; w_daddr = 12'd8; w_ireq = 1; w_iaddr = 12'd2;
    #1;
    chk("nl_dgnt", 32'(w_dgnt), 1);
    chk("nl_ignt", 32'(w_ignt), 0);
    tick();
    chk("nl_dvalid", 32'(r_dvalid), 1);
    chk("nl_rdata", w_rdata, init_val(8));
    w_dreq = 0;
    #1;
    chk("nl_ignt2", 32'(w_ignt), 1);
    idle();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
